// File: rtl/demux_pkg.sv
// Shared encodings for the scanning 1-to-N demultiplexer.
// FSM state values and mode-pin meanings.
package demux_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first enabled channel after start, wrapping back to start itself.
// Combinational, no backpressure; wrap flags a result numerically <= start.
module rr_next_sel #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  ch_en,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] nxt,
  output logic             found,
  output logic             wrap
);

  int idx;

  always_comb begin
    nxt   = start;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(start) + i) % N_CH;
      if (!found && ch_en[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        nxt   = idx[SEL_W-1:0];
      end
    end
    wrap = found && (nxt <= start);
  end

endmodule

// File: rtl/demux_1_n_scan.sv
// Registered 1-to-N_CH demux with enable mask, manual/auto-scan select, dwell and break-before-make gap.
// Data latency 1 cycle from din to y; no backpressure, unselected or masked channels read zero.
module demux_1_n_scan
  import demux_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DATA_W  = 1,
  parameter int DWELL_W = 16,
  parameter int GAP_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_load,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic [DATA_W-1:0]        din,
  output logic [N_CH*DATA_W-1:0]   y,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     sel_valid,
  output logic                     scan_wrap
);

  localparam int         GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [1:0] ST_ENTER = (GAP_CYC == 0) ? ST_ACTIVE : ST_GAP;

  logic [1:0]         state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [SEL_W-1:0]   rr_start;
  logic [SEL_W-1:0]   rr_nxt;
  logic               rr_found;
  logic               rr_wrap;
  logic               sel_in_ok;
  logic               load_ok;
  logic               cur_en;
  logic               gap_done;
  logic               dwell_done;

  // From IDLE the search starts just past the top channel so it lands on the lowest enabled one.
  assign rr_start   = (state == ST_IDLE) ? SEL_W'(N_CH - 1) : cur_sel;
  assign sel_in_ok  = int'(sel_in) < N_CH;
  assign load_ok    = (mode == MODE_MANUAL) && sel_load && sel_in_ok && ch_en[sel_in];
  assign cur_en     = ch_en[cur_sel];
  assign gap_done   = int'(gap_cnt) >= (GAP_CYC - 1);
  assign dwell_done = dwell_cnt >= dwell;
  assign sel_valid  = (state == ST_ACTIVE);

  rr_next_sel #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr (
    .ch_en (ch_en),
    .start (rr_start),
    .nxt   (rr_nxt),
    .found (rr_found),
    .wrap  (rr_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_sel   <= '0;
      gap_cnt   <= '0;
      dwell_cnt <= '0;
      scan_wrap <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mode == MODE_MANUAL) begin
            if (load_ok) begin
              cur_sel   <= sel_in;
              state     <= ST_ENTER;
              gap_cnt   <= '0;
              dwell_cnt <= '0;
            end
          end else if (rr_found) begin
            cur_sel   <= rr_nxt;
            state     <= ST_ENTER;
            gap_cnt   <= '0;
            dwell_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state     <= ST_ACTIVE;
            dwell_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (mode == MODE_MANUAL) begin
            // Held at zero so a later switch to scan starts a fresh dwell.
            dwell_cnt <= '0;
            if (load_ok && (sel_in != cur_sel)) begin
              cur_sel <= sel_in;
              state   <= ST_ENTER;
              gap_cnt <= '0;
            end
          end else if (dwell_done || !cur_en) begin
            if (rr_found) begin
              cur_sel   <= rr_nxt;
              state     <= ST_ENTER;
              gap_cnt   <= '0;
              dwell_cnt <= '0;
              scan_wrap <= rr_wrap;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= '0;
      if ((state == ST_ACTIVE) && cur_en) begin
        y[cur_sel*DATA_W +: DATA_W] <= din;
      end
    end
  end

endmodule

// File: tb/tb_demux_1_n_scan.sv
// Bench for demux_1_n_scan: directed vector table, corner sequences and random traffic vs a reference model.
module tb_demux_1_n_scan;

  localparam int NCH = 12;
  localparam int SW  = 4;
  localparam int DW  = 2;
  localparam int WW  = 8;
  localparam int GC  = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                mode;
  logic [SW-1:0]       sel_in;
  logic                sel_load;
  logic [NCH-1:0]      ch_en;
  logic [WW-1:0]       dwell;
  logic [DW-1:0]       din;
  logic [NCH*DW-1:0]   y;
  logic [SW-1:0]       cur_sel;
  logic                sel_valid;
  logic                scan_wrap;

  always #5 clk = ~clk;

  demux_1_n_scan #(
    .N_CH(NCH), .SEL_W(SW), .DATA_W(DW), .DWELL_W(WW), .GAP_CYC(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
    .ch_en(ch_en), .dwell(dwell), .din(din), .y(y), .cur_sel(cur_sel),
    .sel_valid(sel_valid), .scan_wrap(scan_wrap)
  );

  int total = 0;
  int bad   = 0;

  typedef enum int {M_IDLE, M_GAP, M_ACT} mst_t;
  mst_t              m_st;
  int                m_sel, m_cnt, m_gap;
  logic              m_wrap;
  logic [NCH*DW-1:0] m_y;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_sel = 0; m_cnt = 0; m_gap = 0; m_wrap = 1'b0; m_y = '0;
  endtask

  task automatic model_go(input int k);
    m_sel = k;
    m_st  = (GC == 0) ? M_ACT : M_GAP;
    m_gap = 0;
    m_cnt = 0;
  endtask

  // One clock of behaviour, from the inputs currently applied.
  task automatic model_step();
    logic [NCH*DW-1:0] ny;
    bit load_ok, found;
    int idx;
    ny = '0;
    if (m_st == M_ACT && ch_en[m_sel]) ny[m_sel*DW +: DW] = din;
    m_wrap  = 1'b0;
    load_ok = (mode == 1'b0) && sel_load && (int'(sel_in) < NCH) && ch_en[sel_in];
    found   = 0;
    case (m_st)
      M_IDLE: begin
        if (mode == 1'b0) begin
          if (load_ok) model_go(int'(sel_in));
        end else begin
          for (int k = 0; k < NCH; k++)
            if (!found && ch_en[k]) begin found = 1; model_go(k); end
        end
      end
      M_GAP: begin
        m_gap++;
        if (m_gap >= GC) begin m_st = M_ACT; m_cnt = 0; end
      end
      default: begin
        if (mode == 1'b0) begin
          m_cnt = 0;
          if (load_ok && int'(sel_in) != m_sel) model_go(int'(sel_in));
        end else if (!ch_en[m_sel] || m_cnt >= int'(dwell)) begin
          for (int off = 1; off <= NCH; off++) begin
            idx = (m_sel + off) % NCH;
            if (!found && ch_en[idx]) begin
              found  = 1;
              m_wrap = (idx <= m_sel);
              model_go(idx);
            end
          end
          if (!found) m_st = M_IDLE;
        end else begin
          m_cnt++;
        end
      end
    endcase
    m_y = ny;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("model_y", y, m_y);
    check("model_ctl", {cur_sel, sel_valid, scan_wrap}, {SW'(m_sel), (m_st == M_ACT), m_wrap});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out", {y, cur_sel, sel_valid, scan_wrap}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic              md;
    logic              ld;
    logic [SW-1:0]     sin;
    logic [NCH-1:0]    en;
    logic [WW-1:0]     dw;
    logic [DW-1:0]     d;
    logic [SW-1:0]     esel;
    logic              evld;
    logic              ewrap;
    logic [NCH*DW-1:0] ey;
  } vec_t;

  vec_t tbl[21];
  int   wraps, actives;
  int   exp_seq[5];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 4'd5,  12'hFFF, 8'd2, 2'd3, 4'd5,  1'b0, 1'b0, 24'h000000};
    tbl[1]  = '{1'b0, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd1, 4'd5,  1'b1, 1'b0, 24'h000000};
    tbl[2]  = '{1'b0, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd2, 4'd5,  1'b1, 1'b0, 24'h000800};
    tbl[3]  = '{1'b0, 1'b1, 4'd13, 12'hFFF, 8'd2, 2'd3, 4'd5,  1'b1, 1'b0, 24'h000C00};
    tbl[4]  = '{1'b0, 1'b1, 4'd5,  12'hFFF, 8'd2, 2'd1, 4'd5,  1'b1, 1'b0, 24'h000400};
    tbl[5]  = '{1'b0, 1'b1, 4'd9,  12'hFFF, 8'd2, 2'd2, 4'd9,  1'b0, 1'b0, 24'h000800};
    tbl[6]  = '{1'b0, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd3, 4'd9,  1'b1, 1'b0, 24'h000000};
    tbl[7]  = '{1'b0, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd1, 4'd9,  1'b1, 1'b0, 24'h040000};
    tbl[8]  = '{1'b0, 1'b0, 4'd0,  12'hDFF, 8'd2, 2'd2, 4'd9,  1'b1, 1'b0, 24'h000000};
    tbl[9]  = '{1'b0, 1'b1, 4'd9,  12'hDFF, 8'd2, 2'd3, 4'd9,  1'b1, 1'b0, 24'h000000};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd3, 4'd9,  1'b1, 1'b0, 24'h0C0000};
    tbl[11] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd1, 4'd9,  1'b1, 1'b0, 24'h040000};
    tbl[12] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd2, 4'd9,  1'b1, 1'b0, 24'h080000};
    tbl[13] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd3, 4'd10, 1'b0, 1'b0, 24'h0C0000};
    tbl[14] = '{1'b1, 1'b1, 4'd0,  12'hFFF, 8'd2, 2'd1, 4'd10, 1'b1, 1'b0, 24'h000000};
    tbl[15] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd1, 4'd10, 1'b1, 1'b0, 24'h100000};
    tbl[16] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd2, 4'd10, 1'b1, 1'b0, 24'h200000};
    tbl[17] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd3, 4'd11, 1'b0, 1'b0, 24'h300000};
    tbl[18] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd2, 2'd0, 4'd11, 1'b1, 1'b0, 24'h000000};
    tbl[19] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd0, 2'd1, 4'd0,  1'b0, 1'b1, 24'h400000};
    tbl[20] = '{1'b1, 1'b0, 4'd0,  12'hFFF, 8'd0, 2'd2, 4'd0,  1'b1, 1'b0, 24'h000000};
    exp_seq = '{0, 2, 5, 7, 0};

    mode = 1'b0; sel_in = '0; sel_load = 1'b0; ch_en = '0; dwell = '0; din = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Directed vectors: manual routing, ignored loads, masking, scan handover and 11->0 wrap.
    for (int i = 0; i < 21; i++) begin
      mode = tbl[i].md; sel_load = tbl[i].ld; sel_in = tbl[i].sin;
      ch_en = tbl[i].en; dwell = tbl[i].dw; din = tbl[i].d;
      cycle();
      check($sformatf("tbl%0d", i), {y, cur_sel, sel_valid, scan_wrap},
            {tbl[i].ey, tbl[i].esel, tbl[i].evld, tbl[i].ewrap});
    end
    sel_load = 1'b0;

    // Reset while a channel is active: outputs drop before any clock edge.
    #2;
    do_reset();

    // Sparse scan mask 0,2,5,7 with 3-cycle dwell; one wrap per lap.
    mode = 1'b1; dwell = 8'd2; ch_en = 12'h0A5;
    wraps = 0;
    for (int c = 1; c <= 17; c++) begin
      din = DW'($urandom);
      cycle();
      if (scan_wrap) wraps++;
      if (c % 4 == 1) check($sformatf("scan_ch%0d", c / 4), {cur_sel, sel_valid}, {SW'(exp_seq[c / 4]), 1'b0});
    end
    check("scan_wraps", wraps, 1);

    // Drop the current channel mid-dwell, then the whole mask.
    cycle();
    cycle();
    ch_en = 12'h0A4;
    cycle();
    check("mask_adv", {cur_sel, sel_valid}, {4'd2, 1'b0});
    cycle();
    ch_en = '0;
    cycle();
    check("all_off_idle", sel_valid, 1'b0);
    cycle();
    check("all_off_y", {y, sel_valid}, 25'h0);

    // Single channel, dwell 0: alternating ACTIVE/GAP with a wrap each advance.
    ch_en = 12'h008; dwell = 8'd0;
    wraps = 0; actives = 0;
    for (int c = 1; c <= 10; c++) begin
      din = DW'($urandom);
      cycle();
      if (scan_wrap) wraps++;
      if (sel_valid) actives++;
    end
    check("single_wraps", wraps, 4);
    check("single_active", actives, 5);

    // Scan lands on ch2, then manual holds it; loads in scan mode do nothing.
    ch_en = 12'h004; dwell = 8'd3;
    cycle();
    cycle();
    mode = 1'b0; ch_en = 12'hFFF;
    for (int c = 0; c < 20; c++) begin din = DW'($urandom); cycle(); end
    check("manual_hold", {cur_sel, sel_valid}, {4'd2, 1'b1});
    mode = 1'b1; ch_en = 12'h004; sel_load = 1'b1; sel_in = 4'd7;
    cycle();
    sel_load = 1'b0;
    check("scan_load_ign", {cur_sel, sel_valid}, {4'd2, 1'b1});

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      sel_load = ($urandom_range(0, 5) == 0);
      sel_in   = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       ch_en = '0;
          1:       ch_en = NCH'(1) << $urandom_range(0, NCH - 1);
          default: ch_en = NCH'($urandom);
        endcase
      end
      if ($urandom_range(0, 29) == 0) dwell = WW'($urandom_range(0, 5));
      din = DW'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
